// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word-organised array behind a req/addr_ok/data_ok
// handshake, fixed response latency, accepts a new request during the response cycle.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        align_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              errQ;
  logic [31:0]       respWord;
  logic [31:0]       rdataQ;
  logic [ADDR_W-1:0] wordIndex;
  logic              reqErr;
  logic              accept;
  logic [31:0]       loadWord;
  logic              unusedAddrBits;

  // Upper address bits are dropped so accesses wrap modulo the array size.
  assign wordIndex      = data_sram_addr[ADDR_W+1:2];
  assign unusedAddrBits = ^data_sram_addr[31:ADDR_W+2];
  assign accept         = data_sram_req & data_sram_addr_ok;

  always_comb begin
    reqErr = 1'b0;
    case (data_sram_size)
      2'd1:    reqErr = data_sram_addr[0];
      2'd2:    reqErr = |data_sram_addr[1:0];
      2'd3:    reqErr = 1'b1;
      default: reqErr = 1'b0;
    endcase
  end

  // Stores and rejected loads answer with zero; good loads sample the array at acceptance.
  assign loadWord = (reqErr | data_sram_wr) ? 32'h0 : mem[wordIndex];

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !reqErr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[wordIndex][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      errQ     <= 1'b0;
      respWord <= 32'h0;
      rdataQ   <= 32'h0;
    end else if (accept) begin
      errQ     <= reqErr;
      respWord <= loadWord;
      if (LATENCY == 1) begin
        state  <= RESP;
        rdataQ <= loadWord;
      end else begin
        state <= WAIT;
        cnt   <= CNT_INIT;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state  <= RESP;
        rdataQ <= respWord;
      end
    end else if (state == RESP) begin
      state <= IDLE;
    end
  end

  assign data_sram_addr_ok = ~rst & ((state == IDLE) | (state == RESP));
  assign data_sram_data_ok = ~rst & (state == RESP);
  assign align_err         = data_sram_data_ok & errQ;
  assign data_sram_rdata   = rst ? 32'h0 : rdataQ;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data SRAM-like port: the target of the MEM-stage load/store requests that carry byte write enables, access length and address.
- Holds a word-organised data array, accepts one request per handshake, and returns data_ok after a fixed latency.
- Supports pipelined accept-during-response.
- Flags misaligned or illegal accesses, and never writes on them.
- Used as the data memory in simulation and in the SoC data port.

Parameters:
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from acceptance edge to data_ok (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- data_sram_addr  in  32  byte address.
- data_sram_wstrb  in  4  byte-lane write enables (lane i = bits 8i+7:8i).
- data_sram_wdata  in  32  store data, already lane-aligned by the CPU.
- data_sram_addr_ok  out  1  request accepted this cycle when req is also high.
- data_sram_data_ok  out  1  one-cycle response pulse.
- data_sram_rdata  out  32  full aligned word; the CPU performs lane select and sign extension.
- align_err  out  1  qualifies data_ok; the access was rejected.

Behaviour:
- Reset: all state and outputs are synchronous to clk. While rst is high, addr_ok = 0, data_ok = 0, rdata = 0, align_err = 0, FSM = IDLE, counter = 0.
- Reset mid-operation: a pending response is dropped (no data_ok). The array is not cleared. A store is committed at acceptance, so a store accepted before reset stays in the array.
- States:
  - IDLE: no request outstanding.
  - WAIT: counting latency.
  - RESP: data_ok = 1 for exactly one cycle.
- addr_ok = ~rst & (state == IDLE or state == RESP). It is combinational from state only and never depends on req.
- Acceptance: on a rising edge where req & addr_ok, latch addr, wr, size and the error flag.
  - LATENCY = 1: go directly to RESP.
  - LATENCY > 1: go to WAIT with cnt = LATENCY-1.
- WAIT: cnt decrements each cycle. When cnt reaches 1, the next state is RESP.
- data_ok timing: data_ok is high exactly LATENCY cycles after the acceptance edge. For example, accepting at edge k with LATENCY = 2 gives data_ok high in the cycle following edge k+1.
- RESP exit: new acceptance in the same cycle restarts the sequence (back-to-back throughput of one access per LATENCY cycles). Otherwise return to IDLE.
- Error check, evaluated at acceptance:
  - size 1 with addr[0] = 1 is an error.
  - size 2 with addr[1:0] != 0 is an error.
  - size 3 is always an error.
- Store, no error: at the acceptance edge, mem[addr[ADDR_W+1:2]] byte lane i <= wdata lane i for each wstrb[i] = 1. wstrb = 0 writes nothing but still responds.
- Store with error: no write occurs.
- Load: the word mem[index] is sampled at the acceptance edge and held in a response register. A same-cycle store is impossible (one request per edge), so read-after-write sees the committed data.
- rdata during data_ok:
  - Load, no error: the sampled word.
  - Load with error: 0.
  - Store: 0.
- rdata outside data_ok holds its last value.
- align_err = data_ok & latched error flag; it is 0 at all other times.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the array size.
- req while addr_ok = 0 is not accepted. The requester must hold req and its fields until addr_ok.

Test Plan:
- Reset release, LATENCY = 2: addr_ok = 1, data_ok = 0. Store word 0xDEADBEEF at 0x10 (wstrb = 0xF), then load 0x10 → data_ok exactly 2 cycles after each acceptance; load returns rdata = 0xDEADBEEF with align_err = 0.
- Byte store: wdata = 0x0000AB00, wstrb = 0x2, addr = 0x11, size = 0 over 0xDEADBEEF → load 0x10 returns 0xDEADABEF.
- Misaligned: load size = 2 at 0x12, and store size = 1 at 0x13 → data_ok with align_err = 1 and rdata = 0 on each; a follow-up load of 0x10 still returns 0xDEADABEF (no write occurred).
- Back-to-back: req held high with 4 loads at 0x0, 0x4, 0x8, 0xC, LATENCY = 2 → each new acceptance occurs in the cycle data_ok rises; exactly 4 data_ok pulses, in order, with correct words.
- Wrap, ADDR_W = 10: store 0x12345678 at 0x1000 → load 0x0 returns 0x12345678.
- Reset mid-WAIT: store accepted, then rst high for 1 cycle before data_ok → no data_ok appears, addr_ok returns 1 after reset, and the stored data is readable.
